// File: rtl/sr_latch_driver.sv
// Registered active-low S_n/R_n pulse driver for a cross-coupled NAND SR latch.
// Optional latch feedback check is built when SR_DRV_VERIFY_EN is defined.
module sr_latch_driver #(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic ready,
  output logic done,
  output logic conflict,
  output logic S_n,
  output logic R_n,
  input  logic q_fb,
  input  logic p_fb,
  output logic fault
);

  localparam int unsigned CntMax = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_W);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_W);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPulseS = 2'd1;
  localparam logic [1:0] StPulseR = 2'd2;
  localparam logic [1:0] StGap    = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            s_n_q, s_n_d;
  logic            r_n_q, r_n_d;
  logic            done_q, done_d;
  logic            conflict_q, conflict_d;

  // Latch drive levels are computed for the state being entered, so S_n/R_n
  // come straight from flops and line up with the state register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s_n_d      = 1'b1;
    r_n_d      = 1'b1;
    done_d     = 1'b0;
    conflict_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (set_req && !clr_req) begin
          state_d = StPulseS;
          cnt_d   = PulseLoad;
          s_n_d   = 1'b0;
        end else if (clr_req && !set_req) begin
          state_d = StPulseR;
          cnt_d   = PulseLoad;
          r_n_d   = 1'b0;
        end else if (set_req && clr_req) begin
          conflict_d = 1'b1;
        end
      end
      StPulseS: begin
        if (cnt_q == CntOne) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
          s_n_d = 1'b0;
        end
      end
      StPulseR: begin
        if (cnt_q == CntOne) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
          r_n_d = 1'b0;
        end
      end
      StGap: begin
        if (cnt_q == CntOne) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      s_n_q      <= 1'b1;
      r_n_q      <= 1'b1;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_n_q      <= s_n_d;
      r_n_q      <= r_n_d;
      done_q     <= done_d;
      conflict_q <= conflict_d;
    end
  end

  assign ready    = (state_q == StIdle);
  assign done     = done_q;
  assign conflict = conflict_q;
  assign S_n      = s_n_q;
  assign R_n      = r_n_q;

`ifdef SR_DRV_VERIFY_EN
  logic last_set_q, last_set_d;
  logic fault_q, fault_d;
  logic fb_ok;

  // Feedback is judged on the final gap cycle, once the latch has settled.
  always_comb begin
    last_set_d = last_set_q;
    if (state_q == StIdle && (set_req != clr_req)) begin
      last_set_d = set_req;
    end
    fb_ok   = last_set_q ? (q_fb && !p_fb) : (!q_fb && p_fb);
    fault_d = fault_q;
    if (state_q == StGap && cnt_q == CntOne && !fb_ok) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_set_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      last_set_q <= last_set_d;
      fault_q    <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  logic unused_fb;
  assign unused_fb = q_fb ^ p_fb;
  assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: two instances (4/2 and 1/1) against a timeline model.
module tb_sr_latch_driver;

`ifdef SR_DRV_VERIFY_EN
  localparam bit VerifyEn = 1'b1;
`else
  localparam bit VerifyEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, set_req, clr_req;
  logic [1:0] ready, done, conflict, s_n, r_n, fault, q_fb, p_fb;
  logic [1:0] lat = 2'b00;
  logic       stuck = 1'b0;
  logic       chk_en = 1'b0;
  int         total = 0;
  int         bad = 0;

  sr_latch_driver #(.PULSE_W(4), .GAP_W(2)) u_dut0 (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .ready(ready[0]), .done(done[0]), .conflict(conflict[0]),
    .S_n(s_n[0]), .R_n(r_n[0]), .q_fb(q_fb[0]), .p_fb(p_fb[0]), .fault(fault[0])
  );

  sr_latch_driver #(.PULSE_W(1), .GAP_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .ready(ready[1]), .done(done[1]), .conflict(conflict[1]),
    .S_n(s_n[1]), .R_n(r_n[1]), .q_fb(q_fb[1]), .p_fb(p_fb[1]), .fault(fault[1])
  );

  // Behavioural NAND latches; instance 0 can have Q stuck low.
  always @(s_n, r_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!s_n[i]) lat[i] = 1'b1;
      else if (!r_n[i]) lat[i] = 1'b0;
    end
  end
  assign q_fb = {lat[1], lat[0] & ~stuck};
  assign p_fb = ~q_fb;

  function automatic int pw(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int gw(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(string nm, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_k counts cycles since acceptance (1..PW+GW) for each instance.
  logic [1:0] m_act, m_kind, m_done, m_conf, m_fault;
  int         m_k [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i]   <= 1'b0;
        m_kind[i]  <= 1'b0;
        m_done[i]  <= 1'b0;
        m_conf[i]  <= 1'b0;
        m_fault[i] <= 1'b0;
        m_k[i]     <= 0;
      end else begin
        m_done[i] <= 1'b0;
        m_conf[i] <= 1'b0;
        if (!m_act[i]) begin
          if (set_req != clr_req) begin
            m_act[i]  <= 1'b1;
            m_kind[i] <= set_req;
            m_k[i]    <= 1;
          end else if (set_req) begin
            m_conf[i] <= 1'b1;
          end
        end else if (m_k[i] == pw(i) + gw(i)) begin
          m_act[i]  <= 1'b0;
          m_done[i] <= 1'b1;
          if (VerifyEn && (q_fb[i] != m_kind[i] || p_fb[i] == m_kind[i])) m_fault[i] <= 1'b1;
        end else begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m%0d ready", i), ready[i], !m_act[i]);
        chk($sformatf("m%0d S_n", i), s_n[i], !(m_act[i] && m_kind[i] && m_k[i] <= pw(i)));
        chk($sformatf("m%0d R_n", i), r_n[i], !(m_act[i] && !m_kind[i] && m_k[i] <= pw(i)));
        chk($sformatf("m%0d done", i), done[i], m_done[i]);
        chk($sformatf("m%0d conflict", i), conflict[i], m_conf[i]);
        chk($sformatf("m%0d fault", i), fault[i], m_fault[i]);
        if (!s_n[i] && !r_n[i]) chk($sformatf("m%0d forbidden", i), 1'b1, 1'b0);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  int ndone;

  initial begin
    rst = 1'b1; set_req = 1'b0; clr_req = 1'b0;
    tick(2);
    chk("rst S_n", s_n[0], 1'b1);
    chk("rst R_n", r_n[0], 1'b1);
    chk("rst ready", ready[0], 1'b1);
    chk("rst done", done[0], 1'b0);
    chk("rst conflict", conflict[0], 1'b0);
    chk("rst fault", fault[0], 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(2);

    // Set: accepted at t0, this tick lands in cycle t0+1.
    set_req = 1'b1; tick(); set_req = 1'b0;
    chk("set t1 S_n", s_n[0], 1'b0);
    chk("set t1 ready", ready[0], 1'b0);
    chk("c11 t1 S_n", s_n[1], 1'b0);
    tick();
    chk("c11 t2 S_n", s_n[1], 1'b1);
    chk("c11 t2 ready", ready[1], 1'b0);
    tick();
    chk("c11 t3 ready", ready[1], 1'b1);
    chk("c11 t3 done", done[1], 1'b1);
    tick();
    chk("set t4 S_n", s_n[0], 1'b0);
    tick();
    chk("set t5 S_n", s_n[0], 1'b1);
    chk("set t5 ready", ready[0], 1'b0);
    tick(2);
    chk("set t7 ready", ready[0], 1'b1);
    chk("set t7 done", done[0], 1'b1);
    chk("set t7 R_n", r_n[0], 1'b1);
    tick();
    chk("set t8 done", done[0], 1'b0);

    // Conflict in idle.
    set_req = 1'b1; clr_req = 1'b1; tick(); set_req = 1'b0; clr_req = 1'b0;
    chk("conf strobe", conflict[0], 1'b1);
    chk("conf S_n", s_n[0], 1'b1);
    chk("conf R_n", r_n[0], 1'b1);
    chk("conf ready", ready[0], 1'b1);
    tick();
    chk("conf clears", conflict[0], 1'b0);

    // Busy drop: clear request during a set pulse.
    set_req = 1'b1; tick(); set_req = 1'b0;
    tick(); clr_req = 1'b1; tick(); clr_req = 1'b0;
    chk("drop R_n", r_n[0], 1'b1);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (done[0]) ndone++;
      tick();
    end
    chk("drop one done", ndone == 1, 1'b1);

    // Reset in the middle of a clear pulse.
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    tick();
    chk("mid R_n low", r_n[0], 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid R_n high", r_n[0], 1'b1);
    chk("mid ready", ready[0], 1'b1);
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      if (done[0]) ndone++;
      tick();
    end
    chk("mid no done", ndone == 0, 1'b1);
    set_req = 1'b1; tick(); set_req = 1'b0;
    chk("mid new set", s_n[0], 1'b0);
    tick(8);

`ifdef SR_DRV_VERIFY_EN
    stuck = 1'b1;
    set_req = 1'b1; tick(); set_req = 1'b0;
    tick(5);
    chk("vfy t6 fault", fault[0], 1'b0);
    tick();
    chk("vfy t7 fault", fault[0], 1'b1);
    stuck = 1'b0;
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    tick(8);
    chk("vfy sticky", fault[0], 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("vfy rst clears", fault[0], 1'b0);
    tick(2);
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
